// File: rtl/alu_pkg.sv
// Shared constants for the ALU result path: widths, op tags, occupancy encoding.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned ALU_OP_W  = 4;

    localparam logic [ALU_OP_W-1:0] OP_NOT = 4'd0;
    localparam logic [ALU_OP_W-1:0] OP_AND = 4'd1;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 4'd2;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 4'd3;

    // Occupancy of the result stage doubles as its FSM state.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Zero / negative flags of a result word.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_word,
    output logic             o_zero,
    output logic             o_neg
);

    assign o_zero = (i_word == '0);
    assign o_neg  = i_word[WIDTH-1];

endmodule

// File: rtl/alu_result_skid_32.sv
// Registered result stage behind the bitwise logic units: 2-entry skid buffer
// carrying result, op tag and write-time flags to the multi-cycle controller.
module alu_result_skid_32
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned OP_W  = ALU_OP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OP_W-1:0]  out_op,
    output logic             out_zero,
    output logic             out_neg,
    output logic [1:0]       occupancy
);

    occ_e             r_state;
    occ_e             w_state_nxt;
    logic             w_accept;
    logic             w_drain;
    logic             w_load_head;
    logic             w_load_skid;
    logic             w_head_from_skid;
    logic             w_in_zero;
    logic             w_in_neg;

    logic [WIDTH-1:0] r_head_data;
    logic [OP_W-1:0]  r_head_op;
    logic             r_head_zero;
    logic             r_head_neg;
    logic [WIDTH-1:0] r_skid_data;
    logic [OP_W-1:0]  r_skid_op;
    logic             r_skid_zero;
    logic             r_skid_neg;

    // Flags are derived once, on the write side, and stored with the entry.
    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .i_word (in_data),
        .o_zero (w_in_zero),
        .o_neg  (w_in_neg)
    );

    // Handshakes depend only on the state register, so in_ready has no path from out_ready.
    assign in_ready  = (r_state != OCC_FULL);
    assign out_valid = (r_state != OCC_EMPTY);
    assign occupancy = 2'(r_state);
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;

    // Head register is shown only while valid; otherwise outputs read as reset values.
    assign out_data  = out_valid ? r_head_data : '0;
    assign out_op    = out_valid ? r_head_op   : '0;
    assign out_zero  = out_valid ? r_head_zero : 1'b1;
    assign out_neg   = out_valid ? r_head_neg  : 1'b0;

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OCC_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next occupancy and entry-register steering; flush overrides everything.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_head      = 1'b0;
        w_load_skid      = 1'b0;
        w_head_from_skid = 1'b0;
        case (r_state)
            OCC_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = OCC_ONE;
                    w_load_head = 1'b1;
                end
            end
            OCC_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_head = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = OCC_FULL;
                    w_load_skid = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (w_drain) begin
                    w_state_nxt      = OCC_ONE;
                    w_head_from_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = OCC_EMPTY;
            end
        endcase
        if (flush) begin
            w_state_nxt      = OCC_EMPTY;
            w_load_head      = 1'b0;
            w_load_skid      = 1'b0;
            w_head_from_skid = 1'b0;
        end
    end

    // Head and skid entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_data <= '0;
            r_head_op   <= '0;
            r_head_zero <= 1'b1;
            r_head_neg  <= 1'b0;
            r_skid_data <= '0;
            r_skid_op   <= '0;
            r_skid_zero <= 1'b1;
            r_skid_neg  <= 1'b0;
        end else begin
            if (w_load_head) begin
                r_head_data <= in_data;
                r_head_op   <= in_op;
                r_head_zero <= w_in_zero;
                r_head_neg  <= w_in_neg;
            end else if (w_head_from_skid) begin
                r_head_data <= r_skid_data;
                r_head_op   <= r_skid_op;
                r_head_zero <= r_skid_zero;
                r_head_neg  <= r_skid_neg;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_op   <= in_op;
                r_skid_zero <= w_in_zero;
                r_skid_neg  <= w_in_neg;
            end
        end
    end

`ifndef SYNTHESIS
    // Occupancy stays legal, and accepts never land on a full stage.
    a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
        r_state inside {OCC_EMPTY, OCC_ONE, OCC_FULL});
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == OCC_FULL) |-> !w_accept);
    a_flags_match: assert property (@(posedge clk) disable iff (!rst_n)
        (out_zero == (out_data == '0)) && (out_neg == out_data[WIDTH-1]));
`endif

endmodule
